// File: rtl/branch_fetch_unit.sv
// branch_fetch_unit
//   Program-counter and branch-resolution stage. It compares the branch
//   operand against a second register operand under the decoded condition.
//   It then either advances the PC or redirects it through a small
//   branch-target LUT. Each taken branch inserts one bubble. The block also
//   owns the start/halt handshake and a saturating retired-instruction counter.
//
// Ports
//   Clk, Reset_n        clock (rising edge), asynchronous active-low reset
//   Start               begin execution at PC 0 (honoured in IDLE and HALT)
//   BrMux1, CompareVal  8-bit unsigned branch operands
//   BranchEn            current instruction is a branch
//   BranchCond          00 eq, 01 ne, 10 unsigned lt (BrMux1 < CompareVal), 11 always
//   TargetIdx           LUT index of the branch target
//   HaltInstr           current instruction is halt (wins over BranchEn)
//   LutWe/LutWAddr/LutWData  branch-target LUT write port
//   PC                  current instruction address
//   InstrValid          instruction at PC executes this cycle
//   Taken               high during the bubble cycle that follows a taken branch
//   Done                program halted
//   InstrCount          retired instructions, saturating at 0xFFFF
module branch_fetch_unit #(
  parameter int PC_WIDTH  = 10,
  parameter int LUT_DEPTH = 16,
  localparam int IDX_W    = $clog2(LUT_DEPTH)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic [7:0]          BrMux1,
  input  logic [7:0]          CompareVal,
  input  logic                BranchEn,
  input  logic [1:0]          BranchCond,
  input  logic [IDX_W-1:0]    TargetIdx,
  input  logic                HaltInstr,
  input  logic                LutWe,
  input  logic [IDX_W-1:0]    LutWAddr,
  input  logic [PC_WIDTH-1:0] LutWData,
  output logic [PC_WIDTH-1:0] PC,
  output logic                InstrValid,
  output logic                Taken,
  output logic                Done,
  output logic [15:0]         InstrCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] lut [LUT_DEPTH];
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [15:0]         cnt_nxt;
  logic                valid_nxt, taken_nxt, done_nxt;
  logic                cond_true;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Operands are compared as raw 8-bit unsigned values.
  function automatic logic eval_cond(input logic [1:0] c,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    logic r;
    case (c)
      2'b00:   r = (a == b);
      2'b01:   r = (a != b);
      2'b10:   r = (a < b);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign cond_true = eval_cond(BranchCond, BrMux1, CompareVal);

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    cnt_nxt   = InstrCount;
    valid_nxt = 1'b0;
    taken_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nxt = S_RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
          valid_nxt = 1'b1;
        end
      end
      S_RUN: begin
        // Every RUN cycle retires the instruction at PC, including halt and branches.
        cnt_nxt = sat_inc(InstrCount);
        if (HaltInstr) begin
          state_nxt = S_HALT;
          done_nxt  = 1'b1;
        end else if (BranchEn && cond_true) begin
          // LUT read sees the pre-write contents if the same entry is written now.
          state_nxt = S_FLUSH;
          pc_nxt    = lut[TargetIdx];
          taken_nxt = 1'b1;
        end else begin
          pc_nxt    = PC + PC_ONE;
          valid_nxt = 1'b1;
        end
      end
      S_FLUSH: begin
        state_nxt = S_RUN;
        valid_nxt = 1'b1;
      end
      S_HALT: begin
        done_nxt = 1'b1;
        if (Start) begin
          state_nxt = S_RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
          valid_nxt = 1'b1;
          done_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      PC         <= '0;
      InstrCount <= '0;
      InstrValid <= 1'b0;
      Taken      <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      PC         <= pc_nxt;
      InstrCount <= cnt_nxt;
      InstrValid <= valid_nxt;
      Taken      <= taken_nxt;
      Done       <= done_nxt;
    end
  end

  // Branch-target LUT
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else if (LutWe) begin
      lut[LutWAddr] <= LutWData;
    end
  end

endmodule

// File: tb/tb_branch_fetch_unit.sv
// tb_branch_fetch_unit
//   Directed bench for branch_fetch_unit. A behavioural model tracks the
//   program sequencer from the architectural rules. A compare process checks
//   the DUT against the model on every falling clock edge. Literal expectations
//   at key points pin the model itself.
module tb_branch_fetch_unit;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_BUBB  = 2;
  localparam int M_HALT  = 3;

  logic       Clk, Reset_n, Start, BranchEn, HaltInstr, LutWe;
  logic [7:0] BrMux1, CompareVal;
  logic [1:0] BranchCond;
  logic [3:0] TargetIdx, LutWAddr;
  logic [9:0] LutWData;
  logic [9:0] PC;
  logic       InstrValid, Taken, Done;
  logic [15:0] InstrCount;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model state
  int m_mode;
  int m_pc;
  int m_cnt;
  int m_lut [16];

  branch_fetch_unit #(.PC_WIDTH(10), .LUT_DEPTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .BrMux1(BrMux1), .CompareVal(CompareVal),
    .BranchEn(BranchEn), .BranchCond(BranchCond), .TargetIdx(TargetIdx),
    .HaltInstr(HaltInstr), .LutWe(LutWe), .LutWAddr(LutWAddr), .LutWData(LutWData),
    .PC(PC), .InstrValid(InstrValid), .Taken(Taken), .Done(Done),
    .InstrCount(InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_cnt  = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = 0;
  endfunction

  function automatic bit branch_taken();
    int a, b;
    a = int'(BrMux1);
    b = int'(CompareVal);
    if (!BranchEn) return 0;
    case (BranchCond)
      2'd0:    return a == b;
      2'd1:    return a != b;
      2'd2:    return a < b;
      default: return 1;
    endcase
  endfunction

  function automatic void model_step();
    int tgt;
    tgt = m_lut[TargetIdx];
    if (m_mode == M_IDLE || m_mode == M_HALT) begin
      if (Start) begin
        m_mode = M_RUN;
        m_pc   = 0;
        m_cnt  = 0;
      end
    end else if (m_mode == M_BUBB) begin
      m_mode = M_RUN;
    end else begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (HaltInstr)           m_mode = M_HALT;
      else if (branch_taken()) begin
        m_pc   = tgt;
        m_mode = M_BUBB;
      end else                 m_pc = (m_pc + 1) % 1024;
    end
    if (LutWe) m_lut[LutWAddr] = int'(LutWData);
  endfunction

  always @(negedge Reset_n) model_reset();

  always @(posedge Clk) if (Reset_n === 1'b1) model_step();

  always @(negedge Clk) begin
    if (chk_en) begin
      check("pc",    PC,         m_pc);
      check("valid", InstrValid, m_mode == M_RUN);
      check("taken", Taken,      m_mode == M_BUBB);
      check("done",  Done,       m_mode == M_HALT);
      check("count", InstrCount, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    model_reset();
    Reset_n = 1'b0; Start = 0; BranchEn = 0; HaltInstr = 0; LutWe = 0;
    BrMux1 = 0; CompareVal = 0; BranchCond = 0; TargetIdx = 0;
    LutWAddr = 0; LutWData = 0;
    repeat (2) cyc();
    chk_en = 1;
    check("rst_pc", PC, 0);
    check("rst_valid", InstrValid, 0);
    check("rst_taken", Taken, 0);
    check("rst_done", Done, 0);
    check("rst_cnt", InstrCount, 0);
    #2 Reset_n = 1'b1;

    cyc();
    check("idle_valid", InstrValid, 0);
    Start = 1; cyc(); Start = 0;
    check("start_pc", PC, 0);
    check("start_valid", InstrValid, 1);
    repeat (5) cyc();
    check("run5_cnt", InstrCount, 5);
    check("run5_pc", PC, 5);

    // LUT[3] = 0x120, then a taken equal branch from PC 7
    LutWe = 1; LutWAddr = 3; LutWData = 10'h120; cyc(); LutWe = 0;
    cyc();
    check("pc7", PC, 7);
    BranchEn = 1; BranchCond = 2'b00; BrMux1 = 8'h5A; CompareVal = 8'h5A; TargetIdx = 3;
    cyc(); BranchEn = 0;
    check("eq_taken", Taken, 1);
    check("eq_bubble", InstrValid, 0);
    check("eq_tgt", PC, 10'h120);
    cyc();
    check("eq_valid", InstrValid, 1);
    check("eq_taken_clr", Taken, 0);
    check("eq_pc_hold", PC, 10'h120);

    // Same-cycle write and read of LUT[4] returns the old value (0)
    LutWe = 1; LutWAddr = 4; LutWData = 10'd7;
    BranchEn = 1; BranchCond = 2'b11; TargetIdx = 4;
    cyc(); LutWe = 0; BranchEn = 0;
    check("rdw_old", PC, 0);
    cyc();
    BranchEn = 1; BranchCond = 2'b01; BrMux1 = 8'h10; CompareVal = 8'h11; TargetIdx = 4;
    cyc(); BranchEn = 0;
    check("ne_tgt", PC, 7);
    cyc();
    BranchEn = 1; BranchCond = 2'b00; BrMux1 = 8'h5B; CompareVal = 8'h5A; TargetIdx = 3;
    cyc();
    check("eq_nt_pc", PC, 8);
    check("eq_nt_valid", InstrValid, 1);
    check("eq_nt_taken", Taken, 0);

    // Unsigned less-than
    BranchCond = 2'b10; BrMux1 = 8'h80; CompareVal = 8'h7F;
    cyc();
    check("lt_nt_pc", PC, 9);
    BrMux1 = 8'h01; CompareVal = 8'hFF;
    cyc(); BranchEn = 0;
    check("lt_t_pc", PC, 10'h120);
    check("lt_t_taken", Taken, 1);
    cyc();

    // PC wrap from 0x3FF
    LutWe = 1; LutWAddr = 5; LutWData = 10'h3FE; cyc(); LutWe = 0;
    BranchEn = 1; BranchCond = 2'b11; TargetIdx = 5; cyc(); BranchEn = 0;
    cyc();
    cyc();
    check("pc_3ff", PC, 10'h3FF);
    cyc();
    check("pc_wrap", PC, 0);

    // Halt wins over a true branch
    HaltInstr = 1; BranchEn = 1; BranchCond = 2'b11; TargetIdx = 5;
    cyc(); HaltInstr = 0; BranchEn = 0;
    check("halt_done", Done, 1);
    check("halt_pc", PC, 0);
    check("halt_valid", InstrValid, 0);
    check("halt_taken", Taken, 0);
    repeat (2) cyc();
    check("halt_frozen", PC, 0);
    Start = 1; cyc(); Start = 0;
    check("restart_done", Done, 0);
    check("restart_valid", InstrValid, 1);
    check("restart_cnt", InstrCount, 0);
    cyc();

    // Asynchronous reset in the middle of a bubble
    BranchEn = 1; BranchCond = 2'b11; TargetIdx = 3; cyc(); BranchEn = 0;
    check("pre_rst_taken", Taken, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_pc", PC, 0);
    check("arst_taken", Taken, 0);
    check("arst_valid", InstrValid, 0);
    check("arst_cnt", InstrCount, 0);
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    Start = 1; cyc(); Start = 0;
    check("post_rst_pc", PC, 0);
    check("post_rst_valid", InstrValid, 1);
    cyc();
    BranchEn = 1; BranchCond = 2'b11; TargetIdx = 3; cyc(); BranchEn = 0;
    check("lut_cleared", PC, 0);
    cyc();

    // Start is ignored while running
    Start = 1; cyc(); cyc(); Start = 0;
    check("start_ign_pc", PC, 2);
    check("start_ign_cnt", InstrCount, 4);

    // Counter saturation
    repeat (65540) cyc();
    check("sat_cnt", InstrCount, 16'hFFFF);
    repeat (3) cyc();
    check("sat_hold", InstrCount, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
